// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decoder
// Description : RV32I OP / OP-IMM / LUI decode stage producing a registered
//               ALU control bundle behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_alu_op,
    output logic                  out_use_imm,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_illegal,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [CNT_WIDTH-1:0]  illegal_count
);

    localparam logic [6:0] c_opc_op  = 7'b0110011;
    localparam logic [6:0] c_opc_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui = 7'b0110111;
    localparam logic [6:0] c_f7_zero = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_sll  = 4'b0010;
    localparam logic [3:0] c_alu_slt  = 4'b0011;
    localparam logic [3:0] c_alu_sltu = 4'b0100;
    localparam logic [3:0] c_alu_xor  = 4'b0101;
    localparam logic [3:0] c_alu_srl  = 4'b0110;
    localparam logic [3:0] c_alu_sra  = 4'b0111;
    localparam logic [3:0] c_alu_or   = 4'b1000;
    localparam logic [3:0] c_alu_and  = 4'b1001;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rs2;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_rs2    = in_instr[24:20];

    // Base funct3 mapping shared by OP and OP-IMM (funct7=0 flavour).
    function automatic logic [3:0] f3_to_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_to_op = c_alu_add;
            3'b001:  f3_to_op = c_alu_sll;
            3'b010:  f3_to_op = c_alu_slt;
            3'b011:  f3_to_op = c_alu_sltu;
            3'b100:  f3_to_op = c_alu_xor;
            3'b101:  f3_to_op = c_alu_srl;
            3'b110:  f3_to_op = c_alu_or;
            default: f3_to_op = c_alu_and;
        endcase
    endfunction

    logic                  w_legal;
    logic [3:0]            w_alu_op;
    logic                  w_use_imm;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [4:0]            w_rs1;

    always_comb begin
        w_legal   = 1'b0;
        w_alu_op  = f3_to_op(w_funct3);
        w_use_imm = 1'b0;
        w_imm     = '0;
        w_rs1     = in_instr[19:15];
        case (w_opcode)
            c_opc_op: begin
                if (w_funct7 == c_f7_zero) begin
                    w_legal = 1'b1;
                end else if (w_funct7 == c_f7_alt) begin
                    if (w_funct3 == 3'b000) begin
                        w_legal  = 1'b1;
                        w_alu_op = c_alu_sub;
                    end else if (w_funct3 == 3'b101) begin
                        w_legal  = 1'b1;
                        w_alu_op = c_alu_sra;
                    end
                end
            end
            c_opc_imm: begin
                w_use_imm = 1'b1;
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == c_f7_zero);
                    w_imm   = {{(DATA_WIDTH-5){1'b0}}, w_rs2};
                end else if (w_funct3 == 3'b101) begin
                    w_imm = {{(DATA_WIDTH-5){1'b0}}, w_rs2};
                    if (w_funct7 == c_f7_zero) begin
                        w_legal = 1'b1;
                    end else if (w_funct7 == c_f7_alt) begin
                        w_legal  = 1'b1;
                        w_alu_op = c_alu_sra;
                    end
                end else begin
                    w_legal = 1'b1;
                    w_imm   = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
                end
            end
            c_opc_lui: begin
                w_legal   = 1'b1;
                w_alu_op  = c_alu_add;
                w_use_imm = 1'b1;
                w_imm     = {in_instr[31:12], 12'b0};
                w_rs1     = 5'd0;
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal encodings present a neutral bundle downstream.
        if (!w_legal) begin
            w_alu_op  = c_alu_add;
            w_use_imm = 1'b0;
            w_imm     = '0;
        end
    end

    logic w_accept;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_alu_op    <= '0;
            out_use_imm   <= 1'b0;
            out_imm       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_illegal   <= 1'b0;
            out_pc        <= '0;
            illegal_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid     <= 1'b1;
            out_alu_op    <= w_alu_op;
            out_use_imm   <= w_use_imm;
            out_imm       <= w_imm;
            out_rs1       <= w_rs1;
            out_rs2       <= w_rs2;
            out_rd        <= in_instr[11:7];
            out_reg_write <= w_legal && (in_instr[11:7] != 5'd0);
            out_illegal   <= !w_legal;
            out_pc        <= in_pc;
            if (!w_legal && (illegal_count != '1)) begin
                illegal_count <= illegal_count + c_cnt_one;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_decoder
// Description : Scoreboard bench for alu_op_decoder (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_decoder;

    localparam int c_cw = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic        out_use_imm;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;
    logic [31:0] out_pc;
    logic [c_cw-1:0] illegal_count;

    alu_op_decoder #(.DATA_WIDTH(32), .CNT_WIDTH(c_cw)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_use_imm(out_use_imm), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal),
        .out_pc(out_pc), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            use_imm;
        logic [31:0]     imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rw;
        logic            ill;
        logic [31:0]     pc;
        logic [c_cw-1:0] cnt;
    } bundle_t;

    bundle_t q[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      exp_cnt  = 0;
    int      cyc      = 0;
    logic [31:0] pc_ctr = 32'h1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bundle_t cur();
        bundle_t b;
        b = '{out_alu_op, out_use_imm, out_imm, out_rs1, out_rs2, out_rd,
              out_reg_write, out_illegal, out_pc, illegal_count};
        return b;
    endfunction

    function automatic bundle_t ok(input logic [3:0] op, input logic ui, input logic [31:0] imm,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bundle_t b;
        b = '{op, ui, imm, rs1, rs2, rd, (rd != 5'd0), 1'b0, 32'h0, '0};
        return b;
    endfunction

    function automatic bundle_t bad(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bundle_t b;
        b = '{4'h0, 1'b0, 32'h0, rs1, rs2, rd, 1'b0, 1'b1, 32'h0, '0};
        return b;
    endfunction

    // Scoreboard monitor: one comparison per delivered bundle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 128'(cur()), 128'(0));
            end else begin
                bundle_t e;
                e = q.pop_front();
                chk("bundle", 128'(cur()), 128'(e));
            end
        end
    end

    // Stall monitor: bundle frozen and in_ready low while backpressured.
    bundle_t snap;
    logic    stalled_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && out_valid && stalled_prev) begin
            chk("stall_hold", 128'(cur()), 128'(snap));
        end
        if (!rst && out_valid && !out_ready) begin
            chk("stall_in_ready", 128'(in_ready), 128'(0));
        end
        stalled_prev = !rst && out_valid && !out_ready;
        snap = cur();
    end

    task automatic send(input logic [31:0] ins, input bundle_t e, input bit push);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_ctr;
        e.pc     = pc_ctr;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        if (push) begin
            if (e.ill && exp_cnt < (1 << c_cw) - 1) exp_cnt++;
            e.cnt = exp_cnt[c_cw-1:0];
            q.push_back(e);
        end
        @(posedge clk); #1;
        pc_ctr += 32'd4;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_instr = 32'h0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", 128'(cur()), 128'(0));
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed decode vectors
        send(32'h40208133, ok(4'h1, 0, 32'h0,        5'd1, 5'd2,  5'd2), 1); // sub
        send(32'hFFF00093, ok(4'h0, 1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1), 1); // addi -1
        send(32'h4032D293, ok(4'h7, 1, 32'h3,        5'd5, 5'd3,  5'd5), 1); // srai
        send(32'h123451B7, ok(4'h0, 1, 32'h12345000, 5'd0, 5'd3,  5'd3), 1); // lui
        send(32'h00000000, bad(5'd0, 5'd0, 5'd0), 1);                         // all zero
        send(32'hFFB32213, ok(4'h3, 1, 32'hFFFFFFFB, 5'd6, 5'd27, 5'd4), 1); // slti -5
        send(32'h80013093, ok(4'h4, 1, 32'hFFFFF800, 5'd2, 5'd0,  5'd1), 1); // sltiu
        send(32'h03F09093, bad(5'd1, 5'd31, 5'd1), 1);                        // slli bad f7
        send(32'h01F09093, ok(4'h2, 1, 32'h1F,       5'd1, 5'd31, 5'd1), 1); // slli 31
        send(32'h00208033, ok(4'h0, 0, 32'h0,        5'd1, 5'd2,  5'd0), 1); // add x0
        send(32'h40209133, bad(5'd1, 5'd2, 5'd2), 1);                         // sll alt f7
        send(32'h005251B3, ok(4'h6, 0, 32'h0,        5'd4, 5'd5,  5'd3), 1); // srl
        send(32'h7FF3E313, ok(4'h8, 1, 32'h7FF,      5'd7, 5'd31, 5'd6), 1); // ori
        send(32'h00002083, bad(5'd0, 5'd0, 5'd1), 1);                         // lw
        idle(3);

        // Full-throughput stream
        c0 = cyc;
        send(32'h009473B3, ok(4'h9, 0, 32'h0,        5'd8, 5'd9,  5'd7), 1); // and
        send(32'h005251B3, ok(4'h6, 0, 32'h0,        5'd4, 5'd5,  5'd3), 1);
        send(32'hFFF00093, ok(4'h0, 1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1), 1);
        send(32'h123451B7, ok(4'h0, 1, 32'h12345000, 5'd0, 5'd3,  5'd3), 1);
        chk("throughput_cycles", 128'(cyc - c0), 128'(4));
        idle(3);

        // Backpressure for three cycles mid-stream
        fork
            begin
                send(32'h40208133, ok(4'h1, 0, 32'h0, 5'd1, 5'd2, 5'd2), 1);
                send(32'h4032D293, ok(4'h7, 1, 32'h3, 5'd5, 5'd3, 5'd5), 1);
                send(32'h00000000, bad(5'd0, 5'd0, 5'd0), 1);
                idle(1);
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(3);

        // Flush beats accept
        in_valid = 1'b1; in_instr = 32'h0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_accept_valid", 128'(out_valid), 128'(0));
        chk("flush_accept_count", 128'(illegal_count), 128'(exp_cnt));
        idle(1);

        // Flush while stalled
        out_ready = 1'b0;
        send(32'h009473B3, ok(4'h9, 0, 32'h0, 5'd8, 5'd9, 5'd7), 0);
        in_valid = 1'b1; in_instr = 32'h0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_stall_valid", 128'(out_valid), 128'(0));
        chk("flush_stall_count", 128'(illegal_count), 128'(exp_cnt));
        out_ready = 1'b1;
        idle(2);

        // Reset with a bundle held
        out_ready = 1'b0;
        send(32'h40208133, ok(4'h1, 0, 32'h0, 5'd1, 5'd2, 5'd2), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset_outputs", 128'(cur()), 128'(0));
        chk("midreset_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1; exp_cnt = 0;
        idle(1);

        // Saturation of the illegal counter
        for (int i = 0; i < (1 << c_cw) + 1; i++) begin
            send(32'h00000000, bad(5'd0, 5'd0, 5'd0), 1);
        end
        idle(4);
        chk("saturated_count", 128'(illegal_count), 128'({c_cw{1'b1}}));
        chk("scoreboard_empty", 128'(q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
